i2s_serializer: RTL

I2S_SERIALIZER -- requirements
Module: i2s_serializer

---
 rtl/i2s_serializer_pkg.sv | 29 ++
 rtl/i2s_serializer_clk_gen.sv | 47 ++++
 rtl/i2s_serializer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_serializer_pkg.sv
// -----------------------------------------------------------------------------
// i2s_serializer_pkg
// Shared I2S framing parameters. The async FIFO and i2s_controller import the
// same constants, so slot and frame geometry stay consistent across the audio
// path.
//   SLOT_WIDTH        : serial bit positions per channel slot (32)
//   FRAME_LEN         : serial bit positions per left+right frame (64)
//   DEFAULT_BIT_DEPTH : default PCM sample width (24)
//   BC_WIDTH          : width of the frame bit counter (6)
// -----------------------------------------------------------------------------
package i2s_serializer_pkg;

    localparam int unsigned SLOT_WIDTH        = 32;
    localparam int unsigned FRAME_LEN         = 64;
    localparam int unsigned DEFAULT_BIT_DEPTH = 24;
    localparam int unsigned BC_WIDTH          = $clog2(FRAME_LEN);

    // Channel owning a slot; encodes exactly the lrck level of that slot.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

    // Position of a frame bit counter value inside its slot.
    function automatic logic [4:0] slot_pos(input logic [BC_WIDTH-1:0] bc);
        return bc[4:0];
    endfunction

endpackage

// File: rtl/i2s_serializer_clk_gen.sv
// -----------------------------------------------------------------------------
// i2s_clk_gen
// Divides clk down to the I2S serial clock and flags SCLK falling edges.
//   clk         : system clock, all state updates on its rising edge
//   rst         : synchronous active-high reset (sclk held low)
//   sclk        : serial clock, toggles every SCLK_DIV clk cycles (registered)
//   fall_strobe : high for the clk cycle that ends with sclk going 1->0, so
//                 logic enabled by it updates on the same edge sclk falls
// -----------------------------------------------------------------------------
module i2s_clk_gen #(
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic sclk,
    output logic fall_strobe
);

    localparam int unsigned     CNT_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_r;
    logic             sclk_r;
    logic             toggle_s;

    // Terminal count of the half-period divider.
    always_comb begin
        toggle_s = (div_cnt_r == CNT_LAST);
    end

    // Half-period divider and serial clock register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {CNT_W{1'b0}};
            sclk_r    <= 1'b0;
        end else if (toggle_s) begin
            div_cnt_r <= {CNT_W{1'b0}};
            sclk_r    <= ~sclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
        end
    end

    assign sclk        = sclk_r;
    assign fall_strobe = toggle_s & sclk_r;

endmodule

// File: rtl/i2s_serializer.sv
// -----------------------------------------------------------------------------
// i2s_serializer
// Turns two valid/ready PCM sample streams into a Philips I2S serial stream.
// Each channel has a single-entry buffer; the buffered sample is moved into a
// 32-bit shift register at the start of its slot and shifted out MSB first,
// one SCLK after the lrck edge. A slot that starts with an empty buffer sets
// the sticky underflow flag.
//
// Ports
//   clk                     : system clock (rising edge)
//   rst                     : synchronous active-high reset
//   left_data/_valid/_ready : left PCM sample handshake (two's complement)
//   right_data/_valid/_ready: right PCM sample handshake
//   sclk, lrck, sdin        : I2S serial clock, word select, serial data
//   underflow               : sticky, set when a slot starts without a sample
//
// Build option
//   I2S_UNDERFLOW_HOLD_EN : when defined an underflowed slot repeats the last
//                           sample loaded for that channel; otherwise it
//                           transmits zeros.
// -----------------------------------------------------------------------------
module i2s_serializer
    import i2s_serializer_pkg::*;
#(
    parameter int unsigned BIT_DEPTH = DEFAULT_BIT_DEPTH,
    parameter int unsigned SCLK_DIV  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_DEPTH-1:0] left_data,
    input  logic                 left_valid,
    output logic                 left_ready,
    input  logic [BIT_DEPTH-1:0] right_data,
    input  logic                 right_valid,
    output logic                 right_ready,
    output logic                 sclk,
    output logic                 lrck,
    output logic                 sdin,
    output logic                 underflow
);

    localparam int unsigned PAD_WIDTH = SLOT_WIDTH - BIT_DEPTH;

    logic                  sclk_s;
    logic                  fall_s;

    logic [BIT_DEPTH-1:0]  left_buf_r;
    logic                  left_full_r;
    logic [BIT_DEPTH-1:0]  right_buf_r;
    logic                  right_full_r;

    logic [BC_WIDTH-1:0]   bc_r;
    logic [BC_WIDTH-1:0]   bc_next_s;
    logic [SLOT_WIDTH-1:0] shift_r;
    logic                  lrck_r;
    logic                  sdin_r;
    logic                  underflow_r;

    logic                  left_accept_s;
    logic                  right_accept_s;
    logic                  load_s;
    logic                  load_left_s;
    logic                  load_right_s;
    channel_e              load_ch_s;
    logic                  src_full_s;
    logic [BIT_DEPTH-1:0]  src_data_s;
    logic [BIT_DEPTH-1:0]  hold_data_s;
    logic [BIT_DEPTH-1:0]  sample_s;
    logic [SLOT_WIDTH-1:0] load_word_s;

`ifdef I2S_UNDERFLOW_HOLD_EN
    logic [BIT_DEPTH-1:0]  left_last_r;
    logic [BIT_DEPTH-1:0]  right_last_r;
`endif

    i2s_clk_gen #(
        .SCLK_DIV    (SCLK_DIV)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk_s),
        .fall_strobe (fall_s)
    );

    // Handshake, slot-start detection and selection of the word to serialize.
    always_comb begin
        left_ready     = !left_full_r && !rst;
        right_ready    = !right_full_r && !rst;
        left_accept_s  = left_valid && left_ready;
        right_accept_s = right_valid && right_ready;

        bc_next_s      = bc_r + BC_WIDTH'(1);
        load_ch_s      = channel_e'(bc_r[BC_WIDTH-1]);
        // The fall event leaving p = 0 enters p = 1: that is the load point.
        load_s         = fall_s && (slot_pos(bc_r) == 5'd0);

        load_left_s    = 1'b0;
        load_right_s   = 1'b0;
        src_full_s     = 1'b0;
        src_data_s     = {BIT_DEPTH{1'b0}};
        hold_data_s    = {BIT_DEPTH{1'b0}};

        case (load_ch_s)
            CH_LEFT: begin
                load_left_s = load_s;
                src_full_s  = left_full_r;
                src_data_s  = left_buf_r;
`ifdef I2S_UNDERFLOW_HOLD_EN
                hold_data_s = left_last_r;
`endif
            end
            CH_RIGHT: begin
                load_right_s = load_s;
                src_full_s   = right_full_r;
                src_data_s   = right_buf_r;
`ifdef I2S_UNDERFLOW_HOLD_EN
                hold_data_s  = right_last_r;
`endif
            end
            default: begin
                load_left_s  = 1'b0;
                load_right_s = 1'b0;
            end
        endcase

        if (src_full_s) begin
            sample_s = src_data_s;
        end else begin
            sample_s = hold_data_s;
        end

        // Left-justify the sample in the slot so the shifter always emits
        // from bit 31 and trailing positions fall out as zeros.
        load_word_s = {sample_s, {PAD_WIDTH{1'b0}}};
    end

    // Left buffer; an accept coinciding with a load can only happen on an
    // empty buffer, so the new sample must stay buffered (set wins).
    always_ff @(posedge clk) begin
        if (rst) begin
            left_buf_r  <= {BIT_DEPTH{1'b0}};
            left_full_r <= 1'b0;
        end else if (left_accept_s) begin
            left_buf_r  <= left_data;
            left_full_r <= 1'b1;
        end else if (load_left_s) begin
            left_full_r <= 1'b0;
        end
    end

    // Right buffer, same policy as the left one.
    always_ff @(posedge clk) begin
        if (rst) begin
            right_buf_r  <= {BIT_DEPTH{1'b0}};
            right_full_r <= 1'b0;
        end else if (right_accept_s) begin
            right_buf_r  <= right_data;
            right_full_r <= 1'b1;
        end else if (load_right_s) begin
            right_full_r <= 1'b0;
        end
    end

`ifdef I2S_UNDERFLOW_HOLD_EN
    // Last sample actually taken from each buffer, replayed on underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_last_r  <= {BIT_DEPTH{1'b0}};
            right_last_r <= {BIT_DEPTH{1'b0}};
        end else begin
            if (load_left_s && left_full_r) begin
                left_last_r <= left_buf_r;
            end
            if (load_right_s && right_full_r) begin
                right_last_r <= right_buf_r;
            end
        end
    end
`endif

    // Frame bit counter, word select and serial data, advanced on SCLK falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            bc_r        <= {BC_WIDTH{1'b0}};
            lrck_r      <= 1'b0;
            sdin_r      <= 1'b0;
            shift_r     <= {SLOT_WIDTH{1'b0}};
            underflow_r <= 1'b0;
        end else if (fall_s) begin
            bc_r   <= bc_next_s;
            lrck_r <= bc_next_s[BC_WIDTH-1];
            if (load_s) begin
                sdin_r  <= load_word_s[SLOT_WIDTH-1];
                shift_r <= {load_word_s[SLOT_WIDTH-2:0], 1'b0};
                if (!src_full_s) begin
                    underflow_r <= 1'b1;
                end
            end else if (slot_pos(bc_next_s) == 5'd0) begin
                // p = 0 is the one-bit delay slot after the lrck edge.
                sdin_r  <= 1'b0;
                shift_r <= {SLOT_WIDTH{1'b0}};
            end else begin
                sdin_r  <= shift_r[SLOT_WIDTH-1];
                shift_r <= {shift_r[SLOT_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign sclk      = sclk_s;
    assign lrck      = lrck_r;
    assign sdin      = sdin_r;
    assign underflow = underflow_r;

endmodule
